// File: rtl/pio_pkg.sv
// Shared constants and helpers for the Avalon-MM input PIO.
//   EDGE_*     : edge-mode selectors (rising / falling / any)
//   ADDR_*     : register word addresses
//   edge_bit() : single-bit edge detect for a given mode
package pio_pkg;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_MSET = 3'd4;
  localparam logic [2:0] ADDR_MCLR = 3'd5;

  function automatic logic edge_bit(input int mode, input logic cur, input logic prv);
    case (mode)
      EDGE_RISE: return cur & ~prv;
      EDGE_FALL: return ~cur & prv;
      default:   return cur ^ prv;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// Per-bit debouncer: dout follows din only after din has differed from
// dout for DEBOUNCE_CYCLES consecutive cycles. Built only when
// PIO_DEBOUNCE_EN is defined.
//   clk, reset_n : clock, async active-low reset
//   din          : synchronised input bit
//   dout         : debounced (stable) value, resets to 0
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (din != dout) begin
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        dout <= din;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/avalon_pio_in_irq.sv
// Avalon-MM input PIO with per-bit edge capture and level IRQ.
// Optional per-bit debounce is compiled in with PIO_DEBOUNCE_EN.
//   clk, reset_n        : clock, async active-low reset
//   address, chipselect, write_n, writedata : Avalon-MM slave write side
//   in_port[WIDTH]      : asynchronous inputs
//   readdata[32]        : registered read data (1-cycle latency, no chipselect needed)
//   irq                 : |(edge_capture & irq_mask)
// Map: 0 data (RO), 2 irq_mask, 3 edge_capture (W1C), 4 mask set, 5 mask clear.
module avalon_pio_in_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_MODE       = 1,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, filt, prev;
  logic [WIDTH-1:0] irq_mask, edge_cap, edge_det, wdat;
  logic [1:0]       arm_cnt;
  logic             wr;
  logic [31:0]      rd_mux;

  assign wr   = chipselect & ~write_n;
  assign wdat = writedata[WIDTH-1:0];

  generate
    if (WIDTH < 32) begin : g_pad
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
      pio_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sync2[i]),
        .dout    (filt[i])
      );
    end
  endgenerate
`else
  assign filt = sync2;
`endif

  // Edges are suppressed until the sync chain has flushed its reset zeros.
  always_comb begin
    edge_det = '0;
    for (int i = 0; i < WIDTH; i++)
      edge_det[i] = (arm_cnt == 2'd3) & edge_bit(EDGE_MODE, filt[i], prev[i]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      arm_cnt  <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
    end else begin
      prev <= filt;
      if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
      if (wr) begin
        case (address)
          ADDR_MASK: irq_mask <= wdat;
          ADDR_MSET: irq_mask <= irq_mask | wdat;
          ADDR_MCLR: irq_mask <= irq_mask & ~wdat;
          default:   ;
        endcase
      end
      // Set after clear so a coincident edge wins over the W1C.
      edge_cap <= (edge_cap & ~((wr && address == ADDR_EDGE) ? wdat : '0)) | edge_det;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = 32'(filt);
      ADDR_MASK: rd_mux = 32'(irq_mask);
      ADDR_EDGE: rd_mux = 32'(edge_cap);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_avalon_pio_in_irq.sv
// Self-checking bench: three DUTs (rising / falling / any edge) share one
// stimulus stream; a behavioural model predicts readdata and irq each cycle.
module tb_avalon_pio_in_irq;

`ifdef PIO_DEBOUNCE_EN
  localparam int DB = 8;
`else
  localparam int DB = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect, write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] rd [3];
  logic        irq_o [3];

  always #5 clk = ~clk;

  generate
    for (genvar m = 0; m < 3; m++) begin : g_dut
      avalon_pio_in_irq #(.WIDTH(4), .EDGE_MODE(m), .DEBOUNCE_CYCLES(8)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (rd[m]),
        .irq        (irq_o[m])
      );
    end
  endgenerate

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  s1, s2, m_stable, m_prev, m_mask, f_now;
  logic [3:0]  m_cap [3];
  logic [31:0] m_rd  [3];
  int          nedge;
  int          run [4];

  function automatic logic [3:0] mdl_edge(input int mode, input logic [3:0] f, input logic [3:0] p);
    if (mode == 0) return f & ~p;
    if (mode == 1) return ~f & p;
    return f ^ p;
  endfunction

`ifdef PIO_DEBOUNCE_EN
  assign f_now = m_stable;
`else
  assign f_now = s2;
`endif

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0; s2 <= '0; m_stable <= '0; m_prev <= '0; m_mask <= '0; nedge <= 0;
      for (int i = 0; i < 4; i++) run[i] <= 0;
      for (int m = 0; m < 3; m++) begin m_cap[m] <= '0; m_rd[m] <= '0; end
    end else begin
      s1 <= in_port;
      s2 <= s1;
      m_prev <= f_now;
      if (nedge < 3) nedge <= nedge + 1;
      // Debounce: accept s2 once it has disagreed with stable for DB edges.
      for (int i = 0; i < 4; i++) begin
        if (s2[i] != m_stable[i]) begin
          if (run[i] + 1 >= DB) begin m_stable[i] <= s2[i]; run[i] <= 0; end
          else run[i] <= run[i] + 1;
        end else run[i] <= 0;
      end
      if (chipselect && !write_n) begin
        if (address == 3'd2) m_mask <= writedata[3:0];
        if (address == 3'd4) m_mask <= m_mask | writedata[3:0];
        if (address == 3'd5) m_mask <= m_mask & ~writedata[3:0];
      end
      for (int m = 0; m < 3; m++) begin
        logic [3:0] clr, ed;
        clr = (chipselect && !write_n && address == 3'd3) ? writedata[3:0] : 4'h0;
        ed  = (nedge >= 3) ? mdl_edge(m, f_now, m_prev) : 4'h0;
        m_cap[m] <= (m_cap[m] & ~clr) | ed;
        case (address)
          3'd0:    m_rd[m] <= {28'h0, f_now};
          3'd2:    m_rd[m] <= {28'h0, m_mask};
          3'd3:    m_rd[m] <= {28'h0, m_cap[m]};
          default: m_rd[m] <= 32'h0;
        endcase
      end
    end
  end

  bit cmp_en = 1'b0;
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("readdata_m%0d", m), rd[m], m_rd[m]);
        chk($sformatf("irq_m%0d", m), {31'h0, irq_o[m]}, {31'h0, |(m_cap[m] & m_mask)});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #2; endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    tick();
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input int m, input logic [2:0] a, input logic [31:0] exp, input string nm);
    tick();
    address = a;
    @(posedge clk); @(negedge clk);
    chk(nm, rd[m], exp);
  endtask

  initial begin
    reset_n = 1'b0; in_port = 4'hF; address = 3'd3;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_readdata", rd[2], 32'h0);
    chk("reset_irq", {31'h0, irq_o[2]}, 32'h0);
    tick(); reset_n = 1'b1;

    // Inputs high through reset: arming must hide the 0->F fill.
    repeat (6 + DB) tick();
`ifndef PIO_DEBOUNCE_EN
    rd_chk(2, 3'd3, 32'h0, "arm_no_capture");
`endif
    rd_chk(2, 3'd0, 32'hF, "data_after_reset");

    // Falling edge on bit 2 with mask 0x5.
    wr(3'd2, 32'h5);
    tick(); in_port = 4'hB; address = 3'd3;
    repeat (4 + DB) @(posedge clk);
    @(negedge clk);
    chk("fall_capture", rd[1], 32'h4);
    chk("fall_irq", {31'h0, irq_o[1]}, 32'h1);
    wr(3'd3, 32'h4);
    @(negedge clk);
    chk("w1c_irq_clear", {31'h0, irq_o[1]}, 32'h0);

    // Build capture 0xB then clear only bit 1.
    tick(); in_port = 4'hF;
    repeat (4 + DB) tick();
    wr(3'd3, 32'hF);
    tick(); in_port = 4'h4;
    repeat (4 + DB) tick();
    rd_chk(1, 3'd3, 32'hB, "capture_b");
    wr(3'd3, 32'h2);
    rd_chk(1, 3'd3, 32'h9, "w1c_partial");

    // Coincident set and W1C on bit 0: set wins.
    wr(3'd3, 32'hF);
    tick(); in_port = 4'h5;
    repeat (4 + DB) tick();
    tick(); in_port = 4'h4;
    repeat (DB + 1) tick();
    wr(3'd3, 32'h1);
    rd_chk(1, 3'd3, 32'h1, "set_beats_clear");

    // Atomic mask set/clear; write-only registers read as 0.
    wr(3'd2, 32'h0);
    wr(3'd4, 32'h3);
    wr(3'd5, 32'h1);
    rd_chk(1, 3'd2, 32'h2, "mask_set_clr");
    rd_chk(1, 3'd4, 32'h0, "mset_reads_0");
    rd_chk(1, 3'd5, 32'h0, "mclr_reads_0");
    rd_chk(1, 3'd0, 32'h4, "data_read");

`ifdef PIO_DEBOUNCE_EN
    // Short glitch filtered, long level accepted.
    wr(3'd3, 32'hF);
    tick(); in_port = 4'h5;
    repeat (5) tick();
    in_port = 4'h4;
    repeat (12) tick();
    rd_chk(0, 3'd3, 32'h0, "glitch_filtered");
    tick(); in_port = 4'h5;
    repeat (20) tick();
    rd_chk(0, 3'd0, 32'h5, "level_data");
    rd_chk(0, 3'd3, 32'h1, "level_capture");
`endif

    // Randomised traffic, including mid-run resets.
    for (int c = 0; c < 1500; c++) begin
      tick();
      chipselect = 1'b0; write_n = 1'b1;
      if (!reset_n) reset_n = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset_n = 1'b0;
      if ($urandom_range(0, 5) == 0) in_port = 4'($urandom);
      address = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        chipselect = 1'b1; write_n = 1'($urandom_range(0, 1));
        writedata = $urandom;
      end else if ($urandom_range(0, 7) == 0) begin
        write_n = 1'b0;  // strobe without select must be ignored
        writedata = $urandom;
      end
    end
    tick();
    chipselect = 1'b0; write_n = 1'b1; reset_n = 1'b1;
    repeat (3) tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
